udma_i2s_rx_nch: RTL and testbench
==================================

# udma_i2s_rx_nch

Parametrised N-lane I2S receiver for the uDMA I2S peripheral, running entirely in the system clock domain. It oversamples an external SCK/WS pair and NUM_CHANNELS serial data lines, deserialises left/right slots of configurable word length, and buffers each lane in its own FIFO. Each FIFO is drained by a uDMA RX channel through valid/ready. It succeeds the fixed two-channel receiver and adds:
- a generic lane count;
- per-lane buffering;
- a stereo/mono slot select;
- sticky overflow reporting.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of SD lanes and RX FIFOs (1..8)
- FIFO_DEPTH, 4, words per lane FIFO, power of two, ≥2
- SYNC_STAGES, 2, synchroniser flops on ext_sck_i/ext_ws_i/ext_sd_i (≥2)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- cfg_en_i  in  1  receiver enable
- cfg_bits_word_i  in  5  word length minus one (7 → 8 bits, 31 → 32 bits)
- cfg_lsb_first_i  in  1  1: first bit received is bit 0
- cfg_stereo_i  in  1  1: capture both slots; 0: capture left (WS=0) slot only
- ext_sck_i  in  1  external bit clock, asynchronous
- ext_ws_i  in  1  external word select, asynchronous
- ext_sd_i  in  NUM_CHANNELS  serial data, one bit per lane
- data_o  out  NUM_CHANNELS×32  FIFO head word per lane, right-aligned, upper bits zero
- slot_o  out  NUM_CHANNELS  slot of head word (0 left, 1 right)
- valid_o  out  NUM_CHANNELS  head word valid
- ready_i  in  NUM_CHANNELS  consumer accepts head word
- ovf_o  out  NUM_CHANNELS  sticky overflow flag
- ovf_clr_i  in  NUM_CHANNELS  clears the matching ovf_o bit

## Operation
- Input synchronisation: SCK, WS and SD each pass through SYNC_STAGES flops. A sample event is a synced-SCK 0→1 transition (previous synced value 0, current 1).
- At each sample event, all lanes sample SD and the block samples WS.
- Each lane runs a 3-state FSM:
  - IDLE: waits for the first sample event whose WS differs from the WS of the previous event, then moves to CAPTURE.
  - CAPTURE: the slot equals the new WS value. The bit counter starts at 0 and the first data bit is taken at the next sample event (one-SCK I2S delay). The bit counter increments on every sample event.
  - On counter == cfg_bits_word_i, the word is complete: push it to the FIFO (if the slot is enabled) and move to WAIT.
  - WAIT: ignores further bits. The next WS change re-enters CAPTURE.
  - WS change in CAPTURE before the word is complete: the partial word is discarded without a push, and capture restarts for the new slot.
- Bit placement:
  - MSB-first: shift left, inserting each new bit at bit 0.
  - LSB-first: bit k is written to index k.
  - Bits above cfg_bits_word_i are always zero.
- cfg_stereo_i=0: right-slot words are completed but not pushed.
- cfg_en_i=0:
  - All lanes are forced to IDLE, shift registers and counters are cleared, and FIFOs are flushed.
  - valid_o drops the next cycle. ovf_o is retained.
  - cfg_* inputs change only while cfg_en_i=0; otherwise behaviour is undefined.
- FIFO, per lane, first-word-fall-through:
  - valid_o = not empty; a pop occurs when valid_o & ready_i.
  - A push is accepted when not full, or when full with a pop in the same cycle.
  - A push to a full FIFO without a pop drops the word and sets ovf_o.
  - If ovf_clr_i and a new overflow occur in the same cycle, set wins.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter of width log2(FIFO_DEPTH)+1 gives full/empty.

## Timing
- Reset values: data_o=0, slot_o=0, valid_o=0, ovf_o=0; FSMs in IDLE; FIFOs empty.
- Pin-to-event latency: SYNC_STAGES+1 clk cycles from an ext_sck_i rise.
- Last data bit to valid_o: valid_o rises SYNC_STAGES+2 cycles after the ext_sck_i rise carrying the last bit (empty FIFO). data_o/slot_o are valid in the same cycle.
- ext_sck_i high and low phases must each be ≥2 clk_i periods, i.e. f_sck ≤ f_clk/4.
- Throughput: one push and one pop per lane per cycle.
- Lanes are fully independent apart from the shared SCK/WS timing.

## Configuration
- Macro I2S_RX_ERR_CNT_EN.
- When defined, adds output err_cnt_o (NUM_CHANNELS×8):
  - a per-lane saturating count of dropped words (saturates at 255);
  - cleared by rst_i or by the lane's ovf_clr_i;
  - if a drop and a clear occur in the same cycle, the result is 1.
- When undefined: the port and counters are absent; all other behaviour is identical.

## Structure
- Package udma_i2s_rx_pkg holds:
  - the lane FSM state enum (IDLE, CAPTURE, WAIT);
  - the constant MAX_WORD_BITS=32;
  - a helper function clog2 for pointer widths.
- Sub-module udma_i2s_rx_lane contains one lane: FSM, shift register, FIFO and ovf/err counter.
- The top level holds the synchronisers, SCK edge detect and WS-change detect, and instantiates NUM_CHANNELS lanes with a generate loop.

## Test plan
- Stereo, 16-bit, MSB-first, f_sck=f_clk/8: lane0 receives 0xA5C3 left and 0x1234 right → data_o[0]=0x0000A5C3 slot 0, then 0x00001234 slot 1. valid_o rises SYNC_STAGES+2 cycles after the last bit.
- LSB-first, 8-bit, mono: lane2 receives bits 1,0,0,0,0,0,0,0 in the left slot and 0xFF in the right slot → only 0x00000001 is pushed.
- ready_i=0 on lane1, FIFO_DEPTH=4, 6 words sent → 4 words held, ovf_o[1]=1, err_cnt_o[1]=2 (macro on). Words drain in order once ready_i=1.
- WS toggles after 10 bits while cfg_bits_word_i=15 → no push; the next full 16-bit slot is pushed normally.
- Reset mid-word and cfg_en_i deassertion with 3 words queued → valid_o=0 the next cycle. After re-enable, the first push comes only after a new WS change.
- Full FIFO with simultaneous push and pop → push accepted, ovf_o stays 0, occupancy stays at FIFO_DEPTH.

Source files
------------

// File: rtl/udma_i2s_rx_pkg.sv
// Shared types and constants for the N-lane I2S receiver.
package udma_i2s_rx_pkg;

    localparam int MAX_WORD_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        WAIT
    } lane_state_e;

    typedef struct packed {
        logic       en;
        logic [4:0] bits_word;
        logic       lsb_first;
        logic       stereo;
    } cfg_t;

    function automatic int clog2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/udma_i2s_rx_fifo.sv
// Generic first-word-fall-through FIFO with synchronous flush and drop-on-full reporting.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: pop_rdy stalls the head; a push into a full FIFO without a same-cycle pop is dropped.
module udma_i2s_rx_fifo import udma_i2s_rx_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             drop
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             pop;
    logic             push;

    assign pop_vld = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = pop_vld & pop_rdy;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push    = push_vld & (~full | pop);
    assign drop    = push_vld & full & ~pop;
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/udma_i2s_rx_lane.sv
// One I2S receive lane: slot FSM, deserialiser, lane FIFO and sticky overflow (err count with I2S_RX_ERR_CNT_EN).
// Latency: a completed word is pushed on the cycle after its sample event.
// Backpressure: ready stalls the FIFO head; words arriving at a full FIFO are dropped and flagged.
module udma_i2s_rx_lane import udma_i2s_rx_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  cfg_t                     cfg,
    input  logic                     evt,
    input  logic                     ws_chg,
    input  logic                     ws,
    input  logic                     sd,
    output logic [MAX_WORD_BITS-1:0] data,
    output logic                     slot,
    output logic                     valid,
    input  logic                     ready,
    output logic                     ovf,
    input  logic                     ovf_clr
`ifdef I2S_RX_ERR_CNT_EN
    ,
    output logic [7:0]               err_cnt
`endif
);

    lane_state_e              state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [MAX_WORD_BITS-1:0] shift_q, shift_d, shift_new;
    logic                     slot_q, slot_d;
    logic                     push_vld;
    logic                     drop;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        slot_d    = slot_q;
        push_vld  = 1'b0;
        shift_new = cfg.lsb_first ? (shift_q | (MAX_WORD_BITS'(sd) << cnt_q))
                                  : {shift_q[MAX_WORD_BITS-2:0], sd};
        if (!cfg.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            shift_d = '0;
        end else if (evt) begin
            case (state_q)
                CAPTURE: begin
                    shift_d = shift_new;
                    if (cnt_q == cfg.bits_word) begin
                        push_vld = cfg.stereo | ~slot_q;
                        state_d  = WAIT;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
            // A WS change always opens a new slot; an unfinished word is abandoned.
            if (ws_chg) begin
                state_d = CAPTURE;
                cnt_d   = '0;
                shift_d = '0;
                slot_d  = ws;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            slot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            slot_q  <= slot_d;
        end
    end

    udma_i2s_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MAX_WORD_BITS + 1)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush    (~cfg.en),
        .push_vld (push_vld),
        .push_dat ({slot_q, shift_new}),
        .pop_vld  (valid),
        .pop_rdy  (ready),
        .pop_dat  ({slot, data}),
        .drop     (drop)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)        ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

`ifdef I2S_RX_ERR_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)                        err_cnt <= '0;
        else if (ovf_clr)                 err_cnt <= {7'd0, drop};
        else if (drop && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: rtl/udma_i2s_rx_nch.sv
// N-lane I2S receiver top: SCK/WS/SD synchronisers, sample-event and WS-change detect, per-lane FIFOs; I2S_RX_ERR_CNT_EN adds err_cnt_o.
// Latency: sample event SYNC_STAGES+1 cycles after an SCK rise; valid_o SYNC_STAGES+2 cycles after the last bit.
// Backpressure: independent valid/ready per lane; a full lane drops words and raises its sticky ovf_o bit.
module udma_i2s_rx_nch import udma_i2s_rx_pkg::*; #(
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  cfg_en_i,
    input  logic [4:0]                            cfg_bits_word_i,
    input  logic                                  cfg_lsb_first_i,
    input  logic                                  cfg_stereo_i,
    input  logic                                  ext_sck_i,
    input  logic                                  ext_ws_i,
    input  logic [NUM_CHANNELS-1:0]               ext_sd_i,
    output logic [NUM_CHANNELS*MAX_WORD_BITS-1:0] data_o,
    output logic [NUM_CHANNELS-1:0]               slot_o,
    output logic [NUM_CHANNELS-1:0]               valid_o,
    input  logic [NUM_CHANNELS-1:0]               ready_i,
    output logic [NUM_CHANNELS-1:0]               ovf_o,
    input  logic [NUM_CHANNELS-1:0]               ovf_clr_i
`ifdef I2S_RX_ERR_CNT_EN
    ,
    output logic [NUM_CHANNELS*8-1:0]             err_cnt_o
`endif
);

    logic [SYNC_STAGES-1:0]                   sck_sync;
    logic [SYNC_STAGES-1:0]                   ws_sync;
    logic [SYNC_STAGES-1:0][NUM_CHANNELS-1:0] sd_sync;
    logic                                     sck_s, ws_s, evt;
    logic                                     sck_prev, ws_last;
    logic                                     evt_q, ws_q, ws_chg_q;
    logic [NUM_CHANNELS-1:0]                  sd_q;
    cfg_t                                     cfg;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ws_s  = ws_sync[SYNC_STAGES-1];
    assign evt   = sck_s & ~sck_prev;
    assign cfg   = '{en: cfg_en_i, bits_word: cfg_bits_word_i,
                     lsb_first: cfg_lsb_first_i, stereo: cfg_stereo_i};

    // The event and its samples are registered so every lane sees one aligned strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_prev <= 1'b0;
            ws_last  <= 1'b0;
            evt_q    <= 1'b0;
            ws_q     <= 1'b0;
            ws_chg_q <= 1'b0;
            sd_q     <= '0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], ext_sck_i};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ext_ws_i};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], ext_sd_i};
            sck_prev <= sck_s;
            evt_q    <= evt;
            ws_chg_q <= evt & (ws_s != ws_last);
            if (evt) begin
                ws_last <= ws_s;
                ws_q    <= ws_s;
                sd_q    <= sd_sync[SYNC_STAGES-1];
            end
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
        udma_i2s_rx_lane #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .cfg     (cfg),
            .evt     (evt_q),
            .ws_chg  (ws_chg_q),
            .ws      (ws_q),
            .sd      (sd_q[i]),
            .data    (data_o[i*MAX_WORD_BITS +: MAX_WORD_BITS]),
            .slot    (slot_o[i]),
            .valid   (valid_o[i]),
            .ready   (ready_i[i]),
            .ovf     (ovf_o[i]),
            .ovf_clr (ovf_clr_i[i])
`ifdef I2S_RX_ERR_CNT_EN
            ,
            .err_cnt (err_cnt_o[i*8 +: 8])
`endif
        );
    end

endmodule

// File: tb/tb_udma_i2s_rx_nch.sv
// Directed bench for udma_i2s_rx_nch with a per-lane expected-word scoreboard.
module tb_udma_i2s_rx_nch;

    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cfg_en_i;
    logic [4:0]        cfg_bits_word_i;
    logic              cfg_lsb_first_i;
    logic              cfg_stereo_i;
    logic              ext_sck_i;
    logic              ext_ws_i;
    logic [NCH-1:0]    ext_sd_i;
    logic [NCH*32-1:0] data_o;
    logic [NCH-1:0]    slot_o;
    logic [NCH-1:0]    valid_o;
    logic [NCH-1:0]    ready_i;
    logic [NCH-1:0]    ovf_o;
    logic [NCH-1:0]    ovf_clr_i;
`ifdef I2S_RX_ERR_CNT_EN
    logic [NCH*8-1:0]  err_cnt_o;
`endif

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [32:0] exp_q [NCH][$];

    always #5 clk_i = ~clk_i;

    udma_i2s_rx_nch #(
        .NUM_CHANNELS (NCH),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_bits_word_i (cfg_bits_word_i),
        .cfg_lsb_first_i (cfg_lsb_first_i),
        .cfg_stereo_i    (cfg_stereo_i),
        .ext_sck_i       (ext_sck_i),
        .ext_ws_i        (ext_ws_i),
        .ext_sd_i        (ext_sd_i),
        .data_o          (data_o),
        .slot_o          (slot_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .ovf_o           (ovf_o),
        .ovf_clr_i       (ovf_clr_i)
`ifdef I2S_RX_ERR_CNT_EN
        ,
        .err_cnt_o       (err_cnt_o)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted head word must match the oldest expectation for its lane.
    always @(negedge clk_i) begin
        for (int l = 0; l < NCH; l++) begin
            if (!rst_i && valid_o[l] && ready_i[l]) begin
                n_asserts++;
                assert (exp_q[l].size() != 0) else begin
                    n_fail++;
                    $error("FAIL lane%0d_unexpected_pop: observed 0x%0h expected no word", l, data_o[l*32 +: 32]);
                end
                if (exp_q[l].size() != 0) begin
                    logic [32:0] e;
                    e = exp_q[l].pop_front();
                    check($sformatf("lane%0d_data", l), data_o[l*32 +: 32], e[31:0]);
                    check($sformatf("lane%0d_slot", l), 32'(slot_o[l]), 32'(e[32]));
                end
            end
        end
    end

    task automatic sck_cycle();
        repeat (4) tick();
        ext_sck_i = 1'b1;
        repeat (4) tick();
        ext_sck_i = 1'b0;
    endtask

    // One WS-change bit (data 0) followed by nbits data bits; lat is the cycle valid_o[0] is first seen after the last rise.
    task automatic send_slot(input logic ws, input int nbits, input logic lsb,
                             input logic [NCH-1:0][31:0] words, input logic [NCH-1:0] exp_mask,
                             input logic [NCH-1:0] rdy_pulse, output int lat);
        lat = 0;
        for (int l = 0; l < NCH; l++)
            if (exp_mask[l]) exp_q[l].push_back({ws, words[l]});
        ext_ws_i = ws;
        ext_sd_i = '0;
        sck_cycle();
        for (int i = 0; i < nbits; i++) begin
            for (int l = 0; l < NCH; l++)
                ext_sd_i[l] = lsb ? words[l][i] : words[l][nbits-1-i];
            if (i == nbits - 1) begin
                repeat (4) tick();
                ext_sck_i = 1'b1;
                for (int n = 1; n <= 6; n++) begin
                    tick();
                    if (valid_o[0] && lat == 0) lat = n;
                    if (n == 3) ready_i = ready_i | rdy_pulse;
                    if (n == 4) ready_i = ready_i & ~rdy_pulse;
                end
                ext_sck_i = 1'b0;
            end else begin
                sck_cycle();
            end
        end
    endtask

    initial begin
        int lat;
        logic [NCH-1:0][31:0] w;
        rst_i = 1'b1; cfg_en_i = 1'b0; cfg_bits_word_i = 5'd15; cfg_lsb_first_i = 1'b0;
        cfg_stereo_i = 1'b1; ext_sck_i = 1'b0; ext_ws_i = 1'b0; ext_sd_i = '0;
        ready_i = '1; ovf_clr_i = '0;
        repeat (4) tick();
        check("rst_data", data_o[31:0] | data_o[63:32] | data_o[95:64] | data_o[127:96], 32'h0);
        check("rst_slot", 32'(slot_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_ovf", 32'(ovf_o), 32'h0);
        rst_i = 1'b0; cfg_en_i = 1'b1;
        repeat (2) tick();

        // Stereo 16-bit MSB-first
        w = '0;
        send_slot(1'b1, 0, 1'b0, w, '0, '0, lat);
        w[0] = 32'hA5C3; w[1] = 32'h0F0F; w[2] = 32'h8001; w[3] = 32'hFFFF;
        send_slot(1'b0, 16, 1'b0, w, 4'hF, '0, lat);
        check("t1_left_latency", 32'(lat), 32'(SYNC + 2));
        w[0] = 32'h1234; w[1] = 32'hF00D; w[2] = 32'h0001; w[3] = 32'h7FFE;
        send_slot(1'b1, 16, 1'b0, w, 4'hF, '0, lat);
        check("t1_right_latency", 32'(lat), 32'(SYNC + 2));

        // Mono 8-bit LSB-first: right slot completes but is not pushed
        cfg_en_i = 1'b0; tick();
        cfg_bits_word_i = 5'd7; cfg_lsb_first_i = 1'b1; cfg_stereo_i = 1'b0; cfg_en_i = 1'b1;
        w[0] = 32'h5A; w[1] = 32'h80; w[2] = 32'h01; w[3] = 32'hC3;
        send_slot(1'b0, 8, 1'b1, w, 4'hF, '0, lat);
        w = '{default: 32'hFF};
        send_slot(1'b1, 8, 1'b1, w, '0, '0, lat);
        repeat (4) tick();
        check("t2_valid_after_mono", 32'(valid_o), 32'h0);

        // Overflow on lane1 with ready held low
        cfg_en_i = 1'b0; tick();
        cfg_bits_word_i = 5'd15; cfg_lsb_first_i = 1'b0; cfg_stereo_i = 1'b1; cfg_en_i = 1'b1;
        ready_i = 4'b1101;
        for (int j = 0; j < 6; j++) begin
            for (int l = 0; l < NCH; l++) w[l] = 32'h1000 + 32'(j) * 32'h111 + 32'(l);
            send_slot(j[0], 16, 1'b0, w, (j < DEPTH) ? 4'hF : 4'b1101, '0, lat);
        end
        repeat (4) tick();
        check("t3_valid1", 32'(valid_o[1]), 32'h1);
        check("t3_head1", data_o[63:32], 32'h1001);
        check("t3_ovf", 32'(ovf_o), 32'h2);
`ifdef I2S_RX_ERR_CNT_EN
        check("t3_err_cnt1", 32'(err_cnt_o[15:8]), 32'd2);
        check("t3_err_cnt0", 32'(err_cnt_o[7:0]), 32'd0);
`endif
        ready_i = '1;
        repeat (8) tick();
        check("t3_drained", 32'(exp_q[1].size()), 32'd0);
        check("t3_ovf_sticky", 32'(ovf_o[1]), 32'h1);
        ovf_clr_i = 4'b0010; tick(); ovf_clr_i = '0;
        check("t3_ovf_cleared", 32'(ovf_o), 32'h0);
`ifdef I2S_RX_ERR_CNT_EN
        check("t3_err_cleared", 32'(err_cnt_o[15:8]), 32'd0);
`endif

        // WS toggles after 10 of 16 bits: partial discarded
        w = '{default: 32'h3FF};
        send_slot(1'b0, 10, 1'b0, w, '0, '0, lat);
        repeat (6) tick();
        check("t4_no_partial_push", 32'(valid_o), 32'h0);
        w[0] = 32'hBEEF; w[1] = 32'h0123; w[2] = 32'hCAFE; w[3] = 32'h8000;
        send_slot(1'b1, 16, 1'b0, w, 4'hF, '0, lat);

        // Reset mid-word, then disable with 3 words queued
        send_slot(1'b0, 5, 1'b0, w, '0, '0, lat);
        rst_i = 1'b1; repeat (2) tick(); rst_i = 1'b0;
        check("t5_rst_valid", 32'(valid_o), 32'h0);
        check("t5_rst_data0", data_o[31:0], 32'h0);
        ready_i = '0;
        for (int j = 0; j < 3; j++) send_slot(~j[0], 16, 1'b0, w, '0, '0, lat);
        repeat (4) tick();
        check("t5_three_queued", 32'(valid_o), 32'hF);
        cfg_en_i = 1'b0; tick();
        check("t5_flush_valid", 32'(valid_o), 32'h0);
        cfg_en_i = 1'b1; ready_i = '1;
        send_slot(1'b1, 16, 1'b0, w, '0, '0, lat);
        repeat (4) tick();
        check("t5_no_push_without_change", 32'(valid_o), 32'h0);
        w[0] = 32'h00C0; w[1] = 32'hFFEE; w[2] = 32'h4242; w[3] = 32'h0F1E;
        send_slot(1'b0, 16, 1'b0, w, 4'hF, '0, lat);

        // Full lane0 FIFO, fifth word arrives in the same cycle as a pop
        ready_i = 4'b1110;
        for (int j = 0; j < DEPTH + 1; j++) begin
            for (int l = 0; l < NCH; l++) w[l] = 32'h2000 + 32'(j) * 32'h101 + 32'(l);
            send_slot(~j[0], 16, 1'b0, w, 4'hF, (j == DEPTH) ? 4'b0001 : 4'b0000, lat);
        end
        repeat (2) tick();
        check("t6_ovf", 32'(ovf_o), 32'h0);
        check("t6_valid0", 32'(valid_o[0]), 32'h1);
        check("t6_head0", data_o[31:0], 32'h2101);
        ready_i = '1;
        repeat (8) tick();
        for (int l = 0; l < NCH; l++) check($sformatf("final_sb_lane%0d", l), 32'(exp_q[l].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
